// File: rtl/hit_tracker.sv
// hit_tracker
//   Collects per-pixel sprite overlaps during active video. Once per frame, on
//   the falling edge of vsync, it updates player HP and score. It also runs the
//   ALIVE / INVULN / DEAD state machine.
//
//   Optional feature macro: HIT_TRACKER_BCD_SCORE_EN
//     defined   -> score is two BCD digits {tens,ones}, 00..99, saturating at 8'h99
//     undefined -> score is binary, saturating at 8'hFF
//
//   Ports
//     Clk            in   system clock
//     Reset_n        in   asynchronous active-low reset
//     frame_clk      in   VGA vsync (active low), already in the Clk domain
//     blank_n        in   1 = active video
//     is_player/enemy/attack       in  pixel lies inside that sprite's box
//     player/enemy/attack_index    in  5-bit palette index, 0 = transparent
//     restart        in   level; acted on only in DEAD at a frame end
//     player_hp      out  current HP
//     score          out  enemy hit count
//     player_hit     out  one-cycle pulse when HP is decremented
//     enemy_hit      out  one-cycle pulse on a score event
//     invuln         out  high while in INVULN
//     game_over      out  high while in DEAD
//     state_dbg      out  raw FSM state (0 ALIVE, 1 INVULN, 2 DEAD)
//
//   Frame-event handshake: there is no valid/ready. frame_end is a single-cycle
//   strobe. Every frame-level output updates on the Clk edge that ends the
//   frame_end cycle, and the pulses go low again on the next edge.
module hit_tracker #(
    parameter int MAX_HP        = 5,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       blank_n,
    input  logic       is_player,
    input  logic       is_enemy,
    input  logic       is_attack,
    input  logic [4:0] player_index,
    input  logic [4:0] enemy_index,
    input  logic [4:0] attack_index,
    input  logic       restart,
    output logic [3:0] player_hp,
    output logic [7:0] score,
    output logic       player_hit,
    output logic       enemy_hit,
    output logic       invuln,
    output logic       game_over,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_HP_L = 4'(MAX_HP);
    localparam logic [7:0] INV_L    = 8'(INVULN_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] hp_q, hp_d;
    logic [7:0] score_q, score_d;
    logic [7:0] timer_q, timer_d;
    logic       ph_q, ph_d;
    logic       eh_q, eh_d;
    logic       vs_q;
    logic       pe_acc, ae_acc;

    logic frame_end;
    logic opaque_player, opaque_enemy, opaque_attack;

    assign frame_end     = vs_q & ~frame_clk;
    assign opaque_player = is_player && (player_index != 5'd0);
    assign opaque_enemy  = is_enemy  && (enemy_index  != 5'd0);
    assign opaque_attack = is_attack && (attack_index != 5'd0);

    // Saturating score increment, either BCD or binary.
    function automatic logic [7:0] score_inc(input logic [7:0] s);
        logic [7:0] r;
`ifdef HIT_TRACKER_BCD_SCORE_EN
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
`else
        if (s == 8'hFF)
            r = s;
        else
            r = s + 8'd1;
`endif
        return r;
    endfunction

    // Overlap accumulators are sticky for the whole frame. Clearing at
    // frame_end takes priority, so a pixel seen in the frame_end cycle itself
    // is dropped rather than carried into the next frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q   <= 1'b1;
            pe_acc <= 1'b0;
            ae_acc <= 1'b0;
        end else begin
            vs_q <= frame_clk;
            if (frame_end) begin
                pe_acc <= 1'b0;
                ae_acc <= 1'b0;
            end else begin
                if (blank_n && opaque_player && opaque_enemy) pe_acc <= 1'b1;
                if (blank_n && opaque_attack && opaque_enemy) ae_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ALIVE;
            hp_q    <= MAX_HP_L;
            score_q <= 8'd0;
            timer_q <= 8'd0;
            ph_q    <= 1'b0;
            eh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            score_q <= score_d;
            timer_q <= timer_d;
            ph_q    <= ph_d;
            eh_q    <= eh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        score_d = score_q;
        timer_d = timer_q;
        ph_d    = 1'b0;
        eh_d    = 1'b0;
        if (frame_end) begin
            case (state_q)
                ALIVE: begin
                    // A killing hit still scores in the same frame.
                    if (ae_acc) begin
                        eh_d    = 1'b1;
                        score_d = score_inc(score_q);
                    end
                    if (pe_acc && (hp_q != 4'd0)) begin
                        hp_d = hp_q - 4'd1;
                        ph_d = 1'b1;
                        if (hp_q == 4'd1) begin
                            state_d = DEAD;
                        end else begin
                            state_d = INVULN;
                            timer_d = INV_L;
                        end
                    end
                end
                INVULN: begin
                    if (ae_acc) begin
                        eh_d    = 1'b1;
                        score_d = score_inc(score_q);
                    end
                    // The timer leaves INVULN on the frame where it reaches
                    // zero. The <= 1 test also catches a zero value.
                    if (timer_q <= 8'd1) begin
                        timer_d = 8'd0;
                        state_d = ALIVE;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                DEAD: begin
                    if (restart) begin
                        hp_d    = MAX_HP_L;
                        score_d = 8'd0;
                        timer_d = 8'd0;
                        state_d = ALIVE;
                    end
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    assign player_hp  = hp_q;
    assign score      = score_q;
    assign player_hit = ph_q;
    assign enemy_hit  = eh_q;
    assign invuln     = (state_q == INVULN);
    assign game_over  = (state_q == DEAD);
    assign state_dbg  = state_q;

endmodule
